// File: rtl/sample_buffer.sv
// -----------------------------------------------------------------------------
// sample_buffer
//
// Synchronous FIFO that decouples the ultrasonic processing pipeline (write
// side) from the receive/AXI unit (read side). The writer pushes one sample per
// cycle. The reader holds send_en high to pull one registered sample per cycle
// onto buf_out. Occupancy and status flags let upstream throttle. A sticky
// overflow flag lets firmware detect samples that were lost.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   wr_en       in   write strobe from the processing stage
//   data_in     in   [FIFO_DATA-1:0] sample to store
//   send_en     in   read request level from the receive unit
//   flush       in   synchronous clear of contents (pointers/count/valid)
//   buf_out     out  [FIFO_DATA-1:0] registered read data
//   buf_valid   out  buf_out was updated by the last edge
//   full        out  count == DEPTH
//   empty       out  count == 0
//   almost_full out  count >= AF_LEVEL
//   count       out  [ADDR_W:0] current occupancy
//   drop_count  out  [15:0] saturating dropped-write counter
//                    (present only when SAMPLE_BUFFER_DROPCNT_EN is defined)
//   overflow    out  sticky: a write was dropped since reset
//
// Optional feature macro: SAMPLE_BUFFER_DROPCNT_EN
// -----------------------------------------------------------------------------
module sample_buffer #(
    parameter int FIFO_DATA = 25,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6,
    parameter int AF_LEVEL  = 56
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [FIFO_DATA-1:0] data_in,
    input  logic                 send_en,
    input  logic                 flush,
    output logic [FIFO_DATA-1:0] buf_out,
    output logic                 buf_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic [ADDR_W:0]      count,
`ifdef SAMPLE_BUFFER_DROPCNT_EN
    output logic [15:0]          drop_count,
`endif
    output logic                 overflow
);

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_AF    = (ADDR_W+1)'(AF_LEVEL);

    // Occupancy class; the control state is carried entirely by r_count.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    logic [FIFO_DATA-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]    r_wr_ptr;
    logic [ADDR_W-1:0]    r_rd_ptr;
    logic [ADDR_W:0]      r_count;
    logic [FIFO_DATA-1:0] r_buf_out;
    logic                 r_buf_valid;
    logic                 r_overflow;

    state_t               w_state;
    logic                 w_rd_fire;
    logic                 w_wr_fire;
    logic                 w_drop;

    always_comb begin
        w_state = ST_PARTIAL;
        if (r_count == '0) begin
            w_state = ST_EMPTY;
        end else if (r_count == C_DEPTH) begin
            w_state = ST_FULL;
        end
    end

    // Flush suppresses both sides for its cycle.
    // A write to a full buffer is accepted only when a read frees a slot on the same edge.
    // With an empty buffer, a simultaneous write and read performs only the write;
    // there is no fall-through path.
    always_comb begin
        w_rd_fire = send_en & ~flush & (w_state != ST_EMPTY);
        w_wr_fire = wr_en & ~flush & ((w_state != ST_FULL) | w_rd_fire);
        w_drop    = wr_en & ~flush & ~w_wr_fire;
    end

    // Storage is never reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_fire) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_wr_fire, w_rd_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // buf_out keeps its last value through flush and idle cycles; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf_out   <= '0;
            r_buf_valid <= 1'b0;
        end else begin
            r_buf_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_buf_out <= r_mem[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef SAMPLE_BUFFER_DROPCNT_EN
    logic [15:0] r_drop_cnt;

    // Saturates so a long overrun cannot wrap back to a small count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_count = r_drop_cnt;
`endif

    assign buf_out     = r_buf_out;
    assign buf_valid   = r_buf_valid;
    assign count       = r_count;
    assign empty       = (w_state == ST_EMPTY);
    assign full        = (w_state == ST_FULL);
    assign almost_full = (r_count >= C_AF);
    assign overflow    = r_overflow;

endmodule

// File: doc/sample_buffer.md
Name: sample_buffer

Overview:
- Synchronous FIFO that holds processed ultrasonic samples between the processing pipeline and the receive/AXI unit.
- The write side takes one 25-bit sample per cycle from the processing stage.
- The read side is driven by the receive unit's send-enable level and presents one sample per cycle on buf_out, which feeds that unit's buf_in.
- Provides occupancy and status flags so upstream can throttle and firmware can detect lost samples.

Parameters:
- FIFO_DATA, 25, sample width in bits; must match the receive unit.
- DEPTH, 64, number of entries; power of two, minimum 4.
- ADDR_W, 6, log2(DEPTH).
- AF_LEVEL, 56, almost_full threshold; range 1..DEPTH-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- wr_en  input  1  write strobe from the processing stage
- data_in  input  FIFO_DATA  sample to store
- send_en  input  1  read request level from the receive unit (its send_enB)
- flush  input  1  synchronous clear of contents, same priority as reset for pointers
- buf_out  output  FIFO_DATA  registered read data, goes to the receive unit's buf_in
- buf_valid  output  1  buf_out updated this cycle
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- count  output  ADDR_W+1  current occupancy
- overflow  output  1  sticky: a write was dropped

Behaviour:
- Reset: on a clk edge with rst_n=0, all of the following are cleared:
  - wr_ptr, rd_ptr, count → 0; buf_out → 0; buf_valid → 0; overflow → 0.
  - Resulting flags: empty=1, full=0, almost_full=0.
  - Memory contents are not cleared.
  - Reset mid-transfer discards all stored data, with no partial output.
- Flush (rst_n=1, flush=1):
  - Pointers and count → 0; buf_valid → 0 on the next edge.
  - buf_out holds its value; overflow is kept.
  - wr_en and send_en are ignored that cycle.
- Read:
  - rd_fire = send_en & (count != 0).
  - On rd_fire: buf_out <= mem[rd_ptr], rd_ptr++, buf_valid <= 1 on the same edge, so data is visible 1 cycle after the request.
  - Otherwise buf_valid <= 0 and buf_out holds.
  - send_en while empty is a no-op: no underflow, pointers unchanged.
- Write:
  - wr_fire = wr_en & ((count != DEPTH) | rd_fire).
  - When full with a simultaneous read, the write is accepted.
  - On wr_fire: mem[wr_ptr] <= data_in, wr_ptr++.
  - wr_en & ~wr_fire sets overflow (sticky until reset); the sample is discarded.
- Empty with simultaneous write and read: the read is not performed (no fall-through). The new word becomes readable on the next cycle.
- Count update: +1 on wr_fire only; −1 on rd_fire only; unchanged when both or neither.
- Pointers: wrap modulo DEPTH (natural ADDR_W rollover).
- Flags: full, empty, almost_full and count are combinational from the registered count; they reflect state after the last edge.
- Ordering: strict FIFO; no reordering or duplication.
- Control states are implicit, tracked by count:
  - EMPTY (count=0)
  - PARTIAL (0 < count < DEPTH)
  - FULL (count=DEPTH)
- State transitions follow the count rules above.

Optional Feature:
- Macro: SAMPLE_BUFFER_DROPCNT_EN.
- Defined:
  - Adds output drop_count [15:0], which increments on every dropped write and saturates at 16'hFFFF.
  - Reset clears it; flush does not.
  - overflow still behaves as specified.
- Undefined: the port and counter are absent; only the sticky overflow flag reports loss.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles with wr_en=1 → empty=1, count=0, buf_valid=0, buf_out=0, overflow=0.
- Basic order: write 0x0000001..0x0000005, then send_en=1 for 5 cycles.
  - buf_valid high 5 cycles, starting 1 cycle after send_en.
  - Values appear 1..5 in order; empty=1 afterwards; then send_en for 2 more cycles → buf_valid=0, count stays 0.
- Fill/overflow: write 65 words with no reads.
  - almost_full rises when count reaches 56; full=1 at count=64.
  - 65th write dropped, overflow=1; with SAMPLE_BUFFER_DROPCNT_EN, drop_count=1.
  - Drain → first 64 values read back, 65th absent.
- Full plus simultaneous read/write: at count=64, assert wr_en=1 (data 0x1ABCDEF) and send_en=1 for one cycle → count stays 64, overflow stays 0, 0x1ABCDEF is read last.
- Empty plus simultaneous read/write: at count=0, assert wr_en and send_en → buf_valid=0 that cycle and count=1. Next cycle with send_en=1 → the word is output and count=0.
- Wrap and mid-stream reset:
  - Stream 200 words with writes and reads interleaved every cycle → data matches the scoreboard across pointer wrap.
  - Then deassert rst_n for 1 cycle with count=10 → count=0, empty=1, and no stale words are output afterwards.
